frog_collision: RTL and testbench
=================================

Name: frog_collision

Overview:
- Consumer end of the car-position interface. Each car sprite publishes a 5-bit column that advances every 0.5 s and wraps from 20 to 0.
- This block samples all lane car columns and the player position whenever either changes. It scans the lanes serially for a collision.
- It decrements lives on a hit, applies an invulnerability cooldown, and flags game over to the top-level game FSM.

Parameters:
- NUM_LANES, 4, number of car lanes; lane k carries a car.
- LANE0_ROW, 1, grid row of lane 0; lane k occupies row LANE0_ROW+k.
- MAX_X, 20, last valid car/player column; columns above MAX_X mean off-screen.
- START_LIVES, 3, lives loaded at reset and on reload; must be 1..3.
- COOLDOWN_CYCLES, 25000000, invulnerability window after a hit (1 s at 25 MHz).

Ports:
- i_Clk, in, 1: 25 MHz clock.
- i_Rst, in, 1: synchronous, active-high reset.
- i_car_x, in, NUM_LANES*5: packed car columns; lane k is at bits [5k+4:5k].
- i_car_valid, in, 1: one-cycle strobe; car columns were just updated.
- i_player_x, in, 5: player column.
- i_player_y, in, 4: player row.
- i_player_moved, in, 1: one-cycle strobe; player position was just updated.
- i_lives_reload, in, 1: one-cycle strobe; starts a new game.
- o_hit, out, 1: one-cycle pulse per registered collision.
- o_lives, out, 2: remaining lives.
- o_game_over, out, 1: level signal, high while lives == 0.
- o_busy, out, 1: high when state is not IDLE.

Behaviour:
- Clocking: one clock, i_Clk. Reset is synchronous, active-high, on i_Rst.
- Reset values: state=IDLE, o_hit=0, o_lives=START_LIVES, o_game_over=0, o_busy=0, lane index=0, pending=0, cooldown counter=0.
- States: IDLE, SCAN, HIT, COOLDOWN, OVER. All outputs are registered.
- IDLE, on trigger (i_car_valid or i_player_moved):
  - Snapshot i_car_x, i_player_x and i_player_y into internal registers.
  - Set lane index to 0 and go to SCAN.
  - Later input changes do not affect the scan in progress.
- SCAN, one lane per cycle. Lane k is hit when all of the following hold:
  - snap_y == LANE0_ROW+k
  - snap_x == snap_car[k]
  - snap_car[k] <= MAX_X
- SCAN transitions:
  - On a hit, go to HIT.
  - If no hit and k == NUM_LANES-1, go to IDLE; if pending is set, go straight back to SCAN with a fresh snapshot instead.
  - Otherwise increment k.
- Latency: trigger sampled at edge t. Lane k is compared during cycle t+1+k. If lane k hits, o_hit is high during cycle t+2+k. Worst-case no-hit scan is NUM_LANES cycles.
- Triggers during SCAN set pending (a single bit; multiple triggers collapse). Pending clears when its rescan starts.
- HIT (one cycle):
  - o_hit=1.
  - o_lives decrements, saturating at 0; 2-bit unsigned arithmetic.
  - If the new lives value is 0: set o_game_over=1 and go to OVER.
  - Otherwise: load the cooldown counter with COOLDOWN_CYCLES-1 and go to COOLDOWN. Pending is cleared.
- COOLDOWN:
  - Counter decrements each cycle. At 0, go to IDLE.
  - Triggers are dropped, not queued.
  - o_hit=0.
- OVER: holds until i_lives_reload. All triggers are ignored.
- i_lives_reload, in any state:
  - o_lives=START_LIVES, o_game_over=0, pending=0, cooldown counter cleared, next state IDLE.
  - Reload has priority over a same-cycle trigger or hit; any hit decision that cycle is discarded.
- Simultaneous i_car_valid and i_player_moved count as one trigger.
- Player x beyond MAX_X is still compared. Car x beyond MAX_X never matches.
- i_Rst mid-scan or mid-cooldown returns all state to reset values on the next edge. No o_hit pulse is emitted.

Decomposition:
- Shared package game_pkg holds:
  - X_W=5, Y_W=4, MAX_X=20, LIVES_W=2.
  - State enum for frog_collision.
  - Lane-slice helper constant (5 bits per lane), shared with the car sprites and renderer.
- One sub-module: cooldown_timer.
  - Loadable down-counter, width $clog2(COOLDOWN_CYCLES).
  - Ports: load, load value, done flag.
  - Reused later for the player respawn delay.

Test Plan (bench overrides COOLDOWN_CYCLES=8):
- No-hit scan: player (5,2), cars {3,7,9,0}, pulse i_car_valid -> o_busy high for exactly 4 cycles, o_hit never 1, o_lives stays 3.
- Hit on lane 1: player (7,2), cars {3,7,9,0}, pulse i_player_moved at edge t -> o_hit=1 only in cycle t+3, o_lives 3->2, o_busy high 8 more cycles, then IDLE.
- Invulnerability: during COOLDOWN, pulse i_car_valid with a colliding snapshot -> no o_hit, o_lives unchanged. After return to IDLE, the same trigger produces a hit.
- Pending rescan: trigger with no hit; 2 cycles later change lane 3 car to match player (x=4,y=4) and pulse i_car_valid -> rescan follows without idle gap, o_hit fires, o_lives decrements once.
- Game over and reload: three separated hits -> o_lives 3,2,1,0, o_game_over=1 after third. Further triggers are ignored. i_lives_reload -> o_lives=3, o_game_over=0, state IDLE.
- Off-screen and reset: car x=31 with player x=31 on its row -> no hit. Assert i_Rst during SCAN -> next cycle o_busy=0, o_lives=3, no o_hit.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and types.
// Used by frog_collision, its interface, and the car sprites / renderer.
// No ports: this package holds only localparams and typedefs.
package game_pkg;

  localparam int X_W     = 5;   // column width (cars and player)
  localparam int Y_W     = 4;   // row width (player)
  localparam int MAX_X   = 20;  // last on-screen column
  localparam int LIVES_W = 2;   // lives counter width

  // Each lane occupies this many bits of a packed car-column bus.
  localparam int LANE_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_HIT      = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_OVER     = 3'd4
  } fc_state_e;

endpackage

// File: rtl/frog_collision_if.sv
// Collision-checker bus: car columns, player position, reload strobe in;
// hit pulse, lives, game-over, busy and debug state out.
//   master : game top / bench (drives the strobes and positions)
//   slave  : frog_collision
// Strobes (i_car_valid, i_player_moved, i_lives_reload) are one-cycle
// pulses with no back-pressure: the consumer samples them on the edge
// where they are high and the producer never waits for an acknowledge.
interface frog_collision_if
  import game_pkg::*;
#(
  parameter int NUM_LANES = 4
) ();

  logic [NUM_LANES*LANE_W-1:0] i_car_x;
  logic                        i_car_valid;
  logic [X_W-1:0]              i_player_x;
  logic [Y_W-1:0]              i_player_y;
  logic                        i_player_moved;
  logic                        i_lives_reload;
  logic                        o_hit;
  logic [LIVES_W-1:0]          o_lives;
  logic                        o_game_over;
  logic                        o_busy;
  fc_state_e                   dbg_state;

  modport master (
    output i_car_x, i_car_valid, i_player_x, i_player_y,
           i_player_moved, i_lives_reload,
    input  o_hit, o_lives, o_game_over, o_busy, dbg_state
  );

  modport slave (
    input  i_car_x, i_car_valid, i_player_x, i_player_y,
           i_player_moved, i_lives_reload,
    output o_hit, o_lives, o_game_over, o_busy, dbg_state
  );

endinterface

// File: rtl/frog_collision_cooldown_timer.sv
// Loadable down-counter. Loading sets the count; it then decrements once
// per cycle and stops at zero. done_o is high while the count is zero.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load load_val_i this cycle
//   load_val_i    : value to load
//   clear_i       : force count to zero (load wins if both asserted)
//   done_o        : count == 0
module cooldown_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/frog_collision.sv
// Frogger collision checker. On a car-column or player-position update it
// snapshots all lanes and the player, scans one lane per cycle for a
// collision, decrements lives on a hit, then holds an invulnerability
// cooldown. Lives reaching zero parks the block in OVER until reload.
// Ports:
//   i_Clk : clock
//   i_Rst : synchronous active-high reset
//   bus   : frog_collision_if slave (positions/strobes in, status out)
module frog_collision
  import game_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int LANE0_ROW       = 1,
  parameter int START_LIVES     = 3,
  parameter int COOLDOWN_CYCLES = 25000000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  frog_collision_if.slave  bus
);

  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W      = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  fc_state_e                   state_q, state_d;
  logic [LANE_IDX_W-1:0]       lane_q, lane_d;
  logic                        pending_q, pending_d;
  logic [NUM_LANES*LANE_W-1:0] snap_car_q;
  logic [X_W-1:0]              snap_x_q;
  logic [Y_W-1:0]              snap_y_q;
  logic                        snap_en;
  logic                        hit_q, hit_d;
  logic [LIVES_W-1:0]          lives_q, lives_d;
  logic                        over_q, over_d;
  logic                        busy_q;
  logic                        cd_load, cd_clear, cd_done;

  logic                        trig;
  logic [X_W-1:0]              lane_car;
  logic                        lane_hit;
  logic                        last_lane;
  logic [LIVES_W-1:0]          lives_dec;

  // Both strobes in the same cycle are a single trigger.
  assign trig      = bus.i_car_valid | bus.i_player_moved;
  assign lane_car  = snap_car_q[lane_q*LANE_W +: X_W];
  // Off-screen cars never collide; the player column is compared as-is.
  assign lane_hit  = (snap_y_q == (Y_W'(LANE0_ROW) + Y_W'(lane_q))) &&
                     (snap_x_q == lane_car) &&
                     (lane_car <= X_W'(MAX_X));
  assign last_lane = (lane_q == LANE_IDX_W'(NUM_LANES - 1));
  assign lives_dec = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);

  cooldown_timer #(.W(CNT_W)) u_cooldown (
    .clk_i      (i_Clk),
    .rst_i      (i_Rst),
    .load_i     (cd_load),
    .load_val_i (CNT_W'(COOLDOWN_CYCLES - 1)),
    .clear_i    (cd_clear),
    .done_o     (cd_done)
  );

  // Next-state and next-output logic. Outputs are registered, so o_hit
  // is decided in the SCAN cycle that finds the hit and shows during HIT.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pending_d = pending_q;
    snap_en   = 1'b0;
    hit_d     = 1'b0;
    lives_d   = lives_q;
    over_d    = over_q;
    cd_load   = 1'b0;
    cd_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          snap_en = 1'b1;
          lane_d  = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (trig) begin
          pending_d = 1'b1;
        end
        if (lane_hit) begin
          state_d = ST_HIT;
          hit_d   = 1'b1;
          lives_d = lives_dec;
          over_d  = (lives_dec == '0);
        end else if (last_lane) begin
          lane_d = '0;
          // A trigger landing on the final lane is folded into the rescan.
          if (pending_q || trig) begin
            snap_en   = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lane_d = lane_q + LANE_IDX_W'(1);
        end
      end

      ST_HIT: begin
        pending_d = 1'b0;
        lane_d    = '0;
        if (over_q) begin
          state_d = ST_OVER;
        end else begin
          cd_load = 1'b1;
          state_d = ST_COOLDOWN;
        end
      end

      ST_COOLDOWN: begin
        if (cd_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_OVER: begin
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reload overrides everything decided above, including a hit.
    if (bus.i_lives_reload) begin
      state_d   = ST_IDLE;
      lane_d    = '0;
      pending_d = 1'b0;
      snap_en   = 1'b0;
      hit_d     = 1'b0;
      lives_d   = LIVES_W'(START_LIVES);
      over_d    = 1'b0;
      cd_load   = 1'b0;
      cd_clear  = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      pending_q  <= 1'b0;
      snap_car_q <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      hit_q      <= 1'b0;
      lives_q    <= LIVES_W'(START_LIVES);
      over_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      pending_q <= pending_d;
      hit_q     <= hit_d;
      lives_q   <= lives_d;
      over_q    <= over_d;
      busy_q    <= (state_d != ST_IDLE);
      if (snap_en) begin
        snap_car_q <= bus.i_car_x;
        snap_x_q   <= bus.i_player_x;
        snap_y_q   <= bus.i_player_y;
      end
    end
  end

  assign bus.o_hit       = hit_q;
  assign bus.o_lives     = lives_q;
  assign bus.o_game_over = over_q;
  assign bus.o_busy      = busy_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_frog_collision.sv
// Directed bench for frog_collision with an 8-cycle cooldown.
// Inputs change and outputs are sampled on the falling edge.
module tb_frog_collision;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frog_collision_if #(.NUM_LANES(4)) bus ();

  frog_collision #(
    .NUM_LANES       (4),
    .LANE0_ROW       (1),
    .START_LIVES     (3),
    .COOLDOWN_CYCLES (8)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;
  int hit_cnt, busy_cnt, hit_at, gap;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] cars(input int c0, input int c1, input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic set_player(input int x, input int y);
    bus.i_player_x = 5'(x);
    bus.i_player_y = 4'(y);
  endtask

  // Raise the chosen strobes for one edge. The first sampled cycle after
  // that edge is index 1 in run().
  task automatic pulse(input logic cv, input logic pm, input logic rl);
    bus.i_car_valid    = cv;
    bus.i_player_moved = pm;
    bus.i_lives_reload = rl;
    tick();
    bus.i_car_valid    = 1'b0;
    bus.i_player_moved = 1'b0;
    bus.i_lives_reload = 1'b0;
  endtask

  // Observe n cycles after a pulse. The pulse already consumed cycle 1's
  // falling edge, so cycle 1 is sampled here first without a tick.
  task automatic run(input int n);
    hit_cnt  = 0;
    busy_cnt = 0;
    hit_at   = 0;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) tick();
      if (bus.o_hit) begin
        hit_cnt++;
        if (hit_at == 0) hit_at = i;
      end
      busy_cnt += int'(bus.o_busy);
    end
  endtask

  initial begin
    bus.i_car_x        = '0;
    bus.i_car_valid    = 1'b0;
    bus.i_player_x     = '0;
    bus.i_player_y     = '0;
    bus.i_player_moved = 1'b0;
    bus.i_lives_reload = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_hit", 32'(bus.o_hit), 0);
    check("rst_lives", 32'(bus.o_lives), 3);
    check("rst_over", 32'(bus.o_game_over), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // No-hit scan: player (5,2), cars {3,7,9,0}
    bus.i_car_x = cars(3, 7, 9, 0);
    set_player(5, 2);
    pulse(1'b1, 1'b0, 1'b0);
    run(8);
    check("nohit_busy", 32'(busy_cnt), 4);
    check("nohit_hits", 32'(hit_cnt), 0);
    check("nohit_lives", 32'(bus.o_lives), 3);

    // Both strobes together are one trigger: still a single 4-cycle scan
    pulse(1'b1, 1'b1, 1'b0);
    run(8);
    check("dual_busy", 32'(busy_cnt), 4);

    // Hit on lane 1: player (7,2); hit in cycle t+3, busy t+1..t+11
    set_player(7, 2);
    pulse(1'b0, 1'b1, 1'b0);
    run(14);
    check("hit1_cnt", 32'(hit_cnt), 1);
    check("hit1_at", 32'(hit_at), 3);
    check("hit1_busy", 32'(busy_cnt), 11);
    check("hit1_lives", 32'(bus.o_lives), 2);
    check("hit1_idle", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Second hit, then a colliding trigger during cooldown is dropped
    pulse(1'b0, 1'b1, 1'b0);
    run(4);
    check("hit2_at", 32'(hit_at), 3);
    check("hit2_lives", 32'(bus.o_lives), 1);
    check("hit2_cool", 32'(bus.dbg_state), 32'(ST_COOLDOWN));
    pulse(1'b1, 1'b0, 1'b0);
    run(12);
    check("cool_hits", 32'(hit_cnt), 0);
    check("cool_lives", 32'(bus.o_lives), 1);
    check("cool_idle", 32'(bus.o_busy), 0);

    // Same trigger after cooldown: third hit, game over
    pulse(1'b1, 1'b0, 1'b0);
    run(4);
    check("hit3_at", 32'(hit_at), 3);
    check("hit3_lives", 32'(bus.o_lives), 0);
    check("hit3_over", 32'(bus.o_game_over), 1);
    check("hit3_state", 32'(bus.dbg_state), 32'(ST_OVER));

    // Triggers ignored while over
    pulse(1'b1, 1'b1, 1'b0);
    run(6);
    check("over_hits", 32'(hit_cnt), 0);
    check("over_busy", 32'(busy_cnt), 6);
    check("over_lives", 32'(bus.o_lives), 0);

    // Reload
    pulse(1'b0, 1'b0, 1'b1);
    check("reload_lives", 32'(bus.o_lives), 3);
    check("reload_over", 32'(bus.o_game_over), 0);
    check("reload_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("reload_busy", 32'(bus.o_busy), 0);

    // Pending rescan: no-hit scan, then lane 3 moves onto player (4,4)
    // two cycles in. Rescan starts t+5, lane 3 hits at t+8, o_hit at t+9.
    bus.i_car_x = cars(0, 9, 7, 3);
    set_player(4, 4);
    pulse(1'b1, 1'b0, 1'b0);
    hit_cnt = 0; busy_cnt = 0; hit_at = 0; gap = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      if (bus.o_hit) begin
        hit_cnt++;
        if (hit_at == 0) hit_at = i;
      end
      if (!bus.o_busy && hit_at == 0) gap = 1;
      busy_cnt += int'(bus.o_busy);
      if (i == 2) begin
        bus.i_car_x     = cars(0, 9, 7, 4);
        bus.i_car_valid = 1'b1;
      end else begin
        bus.i_car_valid = 1'b0;
      end
    end
    check("pend_hits", 32'(hit_cnt), 1);
    check("pend_at", 32'(hit_at), 9);
    check("pend_gap", 32'(gap), 0);
    check("pend_busy", 32'(busy_cnt), 17);
    check("pend_lives", 32'(bus.o_lives), 2);

    // Off-screen: car 31 and player 31 on lane 0's row never match
    bus.i_car_x = cars(31, 9, 7, 3);
    set_player(31, 1);
    pulse(1'b1, 1'b0, 1'b0);
    run(6);
    check("off_hits", 32'(hit_cnt), 0);
    check("off_busy", 32'(busy_cnt), 4);
    check("off_lives", 32'(bus.o_lives), 2);

    // Reset mid-scan, scan would hit lane 1 at t+3
    bus.i_car_x = cars(0, 7, 9, 3);
    set_player(7, 2);
    pulse(1'b0, 1'b1, 1'b0);
    check("rscan_busy", 32'(bus.o_busy), 1);
    rst = 1'b1;
    tick();
    check("rscan_busy0", 32'(bus.o_busy), 0);
    check("rscan_lives", 32'(bus.o_lives), 3);
    check("rscan_hit", 32'(bus.o_hit), 0);
    rst = 1'b0;
    run(5);
    check("rscan_after", 32'(hit_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
